// File: rtl/coeff_pingpong_buf.sv
// Double-buffered coefficient store: two single-port banks that alternate
// between the transform writer and the entropy-side reader, with per-bank nonzero flags.

module ram_1p #(
  parameter int WIDTH      = 512,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  cen,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_r [2**ADDR_WIDTH];
  logic [WIDTH-1:0] rdata_r;

  // Single port: write, or read into an output register that holds between reads.
  always_ff @(posedge clk) begin
    if (cen) begin
      if (wen) begin
        mem_r[addr] <= wdata;
      end else begin
        rdata_r <= mem_r[addr];
      end
    end
  end

  assign rdata = rdata_r;

endmodule

module coeff_pingpong_buf #(
  parameter int WIDTH      = 512,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  wr_done_i,
  output logic                  wr_ready_o,
  output logic                  rd_avail_o,
  output logic                  rd_nz_o,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  rd_done_i,
  output logic                  rd_valid_o,
  output logic [WIDTH-1:0]      rd_data_o
);

  function automatic logic row_nonzero(input logic [WIDTH-1:0] row);
    return |row;
  endfunction

  logic       wr_sel_r;
  logic       rd_sel_r;
  logic       rd_bank_r;
  logic       rd_valid_r;
  logic [1:0] full_cnt_r;
  logic [1:0] nz_r;

  logic       wr_acc_s;
  logic       wr_done_acc_s;
  logic       rd_acc_s;
  logic       rd_done_acc_s;
  logic [1:0] nz_next_s;
  logic [1:0] full_cnt_next_s;

  logic [WIDTH-1:0]      q_s    [2];
  logic [1:0]            cen_s;
  logic [1:0]            wen_s;
  logic [ADDR_WIDTH-1:0] addr_s [2];

  assign wr_ready_o = (full_cnt_r != 2'd2);
  assign rd_avail_o = (full_cnt_r != 2'd0);
  assign rd_nz_o    = nz_r[rd_sel_r];

  assign wr_acc_s      = wr_en_i   & wr_ready_o;
  assign wr_done_acc_s = wr_done_i & wr_ready_o;
  assign rd_acc_s      = rd_en_i   & rd_avail_o;
  assign rd_done_acc_s = rd_done_i & rd_avail_o;

  // Release clears the reader's flag; a nonzero write sets the writer's flag (never the same bank).
  always_comb begin
    nz_next_s = nz_r;
    if (rd_done_acc_s) begin
      nz_next_s[rd_sel_r] = 1'b0;
    end else begin
      nz_next_s[rd_sel_r] = nz_r[rd_sel_r];
    end
    if (wr_acc_s && row_nonzero(wr_data_i)) begin
      nz_next_s[wr_sel_r] = 1'b1;
    end else begin
      nz_next_s[wr_sel_r] = nz_next_s[wr_sel_r];
    end
  end

  // Full-bank count: simultaneous handoff and release cancel out.
  always_comb begin
    case ({wr_done_acc_s, rd_done_acc_s})
      2'b10:   full_cnt_next_s = full_cnt_r + 2'd1;
      2'b01:   full_cnt_next_s = full_cnt_r - 2'd1;
      default: full_cnt_next_s = full_cnt_r;
    endcase
  end

  // Bank ownership, flags and read-valid tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel_r   <= 1'b0;
      rd_sel_r   <= 1'b0;
      rd_bank_r  <= 1'b0;
      rd_valid_r <= 1'b0;
      full_cnt_r <= 2'd0;
      nz_r       <= 2'b00;
    end else begin
      full_cnt_r <= full_cnt_next_s;
      nz_r       <= nz_next_s;
      rd_valid_r <= rd_acc_s;
      if (wr_done_acc_s) wr_sel_r <= ~wr_sel_r;
      if (rd_done_acc_s) rd_sel_r <= ~rd_sel_r;
      if (rd_acc_s)      rd_bank_r <= rd_sel_r;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign wen_s[b]  = wr_acc_s & (wr_sel_r == b[0]);
    assign cen_s[b]  = wen_s[b] | (rd_acc_s & (rd_sel_r == b[0]));
    assign addr_s[b] = wen_s[b] ? wr_addr_i : rd_addr_i;

    ram_1p #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk   (clk),
      .cen   (cen_s[b]),
      .wen   (wen_s[b]),
      .addr  (addr_s[b]),
      .wdata (wr_data_i),
      .rdata (q_s[b])
    );
  end

  assign rd_valid_o = rd_valid_r;
  assign rd_data_o  = q_s[rd_bank_r];

endmodule

// File: tb/tb_coeff_pingpong_buf.sv
// Self-checking bench for coeff_pingpong_buf: a reference bank/flag model feeds
// a queue of expected read rows that is popped when the DUT returns data.

module tb_coeff_pingpong_buf;

  localparam int W  = 512;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_done = 1'b0;
  logic          wr_ready;
  logic          rd_avail;
  logic          rd_nz;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_done = 1'b0;
  logic          rd_valid;
  logic [W-1:0]  rd_data;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem_m [2][32];
  logic [W-1:0] exp_q [$];
  logic         wsel_m, rsel_m;
  logic [1:0]   nz_m;
  int           full_m;
  logic [W-1:0] rows_new [4];

  coeff_pingpong_buf #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .wr_done_i  (wr_done),
    .wr_ready_o (wr_ready),
    .rd_avail_o (rd_avail),
    .rd_nz_o    (rd_nz),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_done_i  (rd_done),
    .rd_valid_o (rd_valid),
    .rd_data_o  (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    r[0] = 1'b1;
    return r;
  endfunction

  // One clock cycle: check flags, drive inputs, advance the model, check the returned row.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                      input logic wdn, input logic re, input logic [AW-1:0] ra, input logic rdn);
    bit wacc, wdacc, racc, rdacc;
    chk("wr_ready", {511'd0, wr_ready}, {511'd0, full_m != 2});
    chk("rd_avail", {511'd0, rd_avail}, {511'd0, full_m != 0});
    chk("rd_nz",    {511'd0, rd_nz},    {511'd0, nz_m[rsel_m]});
    wr_en = we; wr_addr = wa; wr_data = wd; wr_done = wdn;
    rd_en = re; rd_addr = ra; rd_done = rdn;
    wacc  = we  && (full_m != 2);
    wdacc = wdn && (full_m != 2);
    racc  = re  && (full_m != 0);
    rdacc = rdn && (full_m != 0);
    if (racc) exp_q.push_back(mem_m[rsel_m][ra]);
    if (rdacc) nz_m[rsel_m] = 1'b0;
    if (wacc) begin
      mem_m[wsel_m][wa] = wd;
      if (wd != '0) nz_m[wsel_m] = 1'b1;
    end
    if (rdacc) rsel_m = ~rsel_m;
    if (wdacc) wsel_m = ~wsel_m;
    full_m = full_m + int'(wdacc) - int'(rdacc);
    @(posedge clk);
    #1;
    if (racc) begin
      chk("rd_valid", {511'd0, rd_valid}, {511'd0, 1'b1});
      chk("rd_data", rd_data, exp_q.pop_front());
    end else begin
      chk("rd_valid_idle", {511'd0, rd_valid}, {511'd0, 1'b0});
    end
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0; wr_done = 1'b0; rd_en = 1'b0; rd_done = 1'b0;
    #2;
    chk("rst_rd_valid", {511'd0, rd_valid}, {511'd0, 1'b0});
    wsel_m = 1'b0; rsel_m = 1'b0; nz_m = 2'b00; full_m = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_wr_ready", {511'd0, wr_ready}, {511'd0, 1'b1});
    chk("rst_rd_avail", {511'd0, rd_avail}, {511'd0, 1'b0});
    chk("rst_rd_nz",    {511'd0, rd_nz},    {511'd0, 1'b0});
  endtask

  initial begin
    #1;
    do_reset();

    // Row index pattern, then back-to-back readout.
    for (int i = 0; i < 32; i++) step(1'b1, AW'(i), W'(i), 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("t1_avail", {511'd0, rd_avail}, {511'd0, 1'b1});
    chk("t1_nz",    {511'd0, rd_nz},    {511'd0, 1'b1});
    for (int i = 0; i < 32; i++) step(1'b0, '0, '0, 1'b0, 1'b1, AW'(i), 1'b0);
    idle();

    // All-zero bank leaves the coded-block flag clear.
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, AW'(i), '0, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    chk("t2_nz", {511'd0, rd_nz}, {511'd0, 1'b0});
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    chk("t2_avail", {511'd0, rd_avail}, {511'd0, 1'b0});
    idle();

    // Both banks full: writes and handoffs are ignored.
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 32; i++) step(1'b1, AW'(i), rnd_row(), 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    end
    chk("t3_ready", {511'd0, wr_ready}, {511'd0, 1'b0});
    step(1'b1, 5'd3, 512'hFF, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 5'd3, 1'b0);
    idle();

    // Simultaneous handoff and release with one bank full.
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rows_new[i] = rnd_row();
      step(1'b1, AW'(i), rows_new[i], 1'b0, 1'b0, '0, 1'b0);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
    chk("t4_avail", {511'd0, rd_avail}, {511'd0, 1'b1});
    chk("t4_ready", {511'd0, wr_ready}, {511'd0, 1'b1});
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1, AW'(i), 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 5'd0, 1'b0);
    chk("t4_new_row0", rd_data, rows_new[0]);

    // Read together with release still returns the old bank's row.
    step(1'b0, '0, '0, 1'b0, 1'b1, 5'd5, 1'b1);
    chk("t5_avail", {511'd0, rd_avail}, {511'd0, 1'b0});
    step(1'b0, '0, '0, 1'b0, 1'b1, 5'd6, 1'b1);
    idle();

    // Reset while reads stream.
    for (int i = 0; i < 8; i++) step(1'b1, AW'(i), rnd_row(), 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1, AW'(i), 1'b0);
    rd_en = 1'b1;
    do_reset();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coeff_pingpong_buf.md
Name: coeff_pingpong_buf

Overview:
- Parametrised double-buffered coefficient store for the TQ pipeline; successor to the fixed 32x512 single-port coefficient RAM.
- Holds two banks of DEPTH x WIDTH, each built from one single-port RAM instance (ram_1p).
- The transform/quant writer fills one bank while the entropy-side reader drains the other, with bank-level handshakes.
- Tracks a per-bank nonzero flag (coded-block flag) so the reader can skip all-zero blocks.

Parameters:
- WIDTH, 512, bits per row (one row of coefficients).
- ADDR_WIDTH, 5, row address width; each bank has DEPTH = 2**ADDR_WIDTH rows.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en_i  in  1  write one row to the current write bank.
- wr_addr_i  in  ADDR_WIDTH  write row address.
- wr_data_i  in  WIDTH  write row data.
- wr_done_i  in  1  writer finished the current bank; hands it to the reader.
- wr_ready_o  out  1  a bank is free for writing.
- rd_avail_o  out  1  a full bank is ready for reading.
- rd_nz_o  out  1  current read bank received at least one nonzero row.
- rd_en_i  in  1  read one row from the current read bank.
- rd_addr_i  in  ADDR_WIDTH  read row address.
- rd_done_i  in  1  reader finished the current bank; releases it.
- rd_valid_o  out  1  rd_data_o carries the row requested in the previous cycle.
- rd_data_o  out  WIDTH  read row data.

Behaviour:
- State registers:
  - wr_sel (1b): bank being written.
  - rd_sel (1b): bank being read.
  - full_cnt (2b): number of full banks, 0..2.
  - nz[1:0]: per-bank nonzero flags.
- Reset (async, rst_n=0): wr_sel=0, rd_sel=0, full_cnt=0, nz=0, rd_valid_o=0. Resulting outputs: wr_ready_o=1, rd_avail_o=0, rd_nz_o=0. rd_data_o is don't-care until the first rd_valid_o. RAM contents are not cleared.
- Flags, combinational from registers:
  - wr_ready_o = (full_cnt != 2).
  - rd_avail_o = (full_cnt != 0).
  - rd_nz_o = nz[rd_sel].
- Write:
  - wr_en_i while wr_ready_o=1 writes wr_data_i to bank wr_sel, row wr_addr_i, at the clock edge.
  - If wr_data_i != 0, nz[wr_sel] is set at the same edge.
  - wr_en_i while wr_ready_o=0 is ignored: no RAM write, no flag change.
- Write handoff:
  - wr_done_i while wr_ready_o=1: wr_sel toggles and full_cnt increments.
  - wr_done_i while wr_ready_o=0 is ignored.
  - wr_en_i and wr_done_i in the same cycle: the row goes to the old bank, then the bank switches.
- Read:
  - rd_en_i while rd_avail_o=1 reads bank rd_sel, row rd_addr_i.
  - Latency is 1 cycle: rd_data_o and rd_valid_o=1 appear after the next edge.
  - rd_valid_o=0 in any cycle following no accepted read.
  - rd_data_o holds its last value when no read occurs (RAM output-hold semantics).
  - rd_en_i while rd_avail_o=0 is ignored.
  - Back-to-back reads give one row per cycle.
- Read release:
  - rd_done_i while rd_avail_o=1: nz[rd_sel] is cleared, rd_sel toggles, full_cnt decrements.
  - rd_done_i while rd_avail_o=0 is ignored.
  - rd_en_i and rd_done_i in the same cycle: the read targets the old bank, and its data still returns next cycle with rd_valid_o=1.
- Simultaneous wr_done_i and rd_done_i, both accepted: full_cnt is unchanged and both selectors toggle.
  - If the writer's bank equals the released bank, the nz clear and nz set cannot collide.
  - An accepted write never targets rd_sel while that bank is full.
- Bank exclusivity:
  - Writer and reader never access the same bank in one cycle: with full_cnt=1 the selectors differ, with 0 reads are blocked, with 2 writes are blocked.
  - Each bank's single port therefore has at most one access per cycle.
  - Bank b port mapping: cen active when (write to b) or (read from b); wen selects write; addr muxed from the write or read side.
- Reset mid-operation: all bank ownership is discarded immediately and both banks are treated as empty. A read in flight produces no rd_valid_o.
- No overflow: full_cnt cannot exceed 2 or go below 0, because of the gating above.

Test Plan:
- Reset, then write rows 0..31 of bank 0 with data = row index (row 0 = 0), then wr_done_i. Expect rd_avail_o=1, wr_ready_o=1, rd_nz_o=1. Read rows 0..31 back-to-back: each rd_data_o equals its address one cycle after rd_en_i, with rd_valid_o high for 32 consecutive cycles.
- Write bank 0 with all-zero rows, then wr_done_i. Expect rd_nz_o=0. Release with rd_done_i; expect rd_avail_o=0 and nz cleared.
- Fill bank 0 and bank 1 (two wr_done_i pulses) with no reads. Expect wr_ready_o=0. Then wr_en_i with addr 3, data 0xFF: no effect. Reading bank 0 row 3 returns its original value.
- With full_cnt=1, pulse wr_done_i and rd_done_i in the same cycle. Expect full_cnt to stay 1, rd_avail_o=1, and wr_sel/rd_sel both toggled. Subsequent reads return the newly completed bank's data.
- rd_en_i with addr 5 together with rd_done_i. Next cycle expect rd_valid_o=1 and data from the old bank row 5, after which rd_avail_o reflects the decremented count.
- Assert rst_n low while reads are streaming. Expect rd_valid_o=0 immediately, then rd_avail_o=0 and wr_ready_o=1 after release.
